// File: rtl/button_conditioner.sv
// ============================================================================
// button_conditioner
//
// Purpose:
//   Conditions four raw, bouncing, active-low board pushbuttons. The block
//   produces the following outputs:
//     - a debounced, registered active-low level for the system's PIO input
//     - one-cycle press and release strobes for each channel
//     - auto-repeat strobes while a key is held down
//   Each key has its own channel, and all channels are identical and
//   independent. Events that occur on several keys in the same cycle
//   therefore produce their strobes in the same cycle.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 1)
//   REPEAT_DELAY     cycles from press_pulse to the first repeat_pulse
//                    (0 disables auto-repeat)
//   REPEAT_PERIOD    cycles between successive repeat_pulse (>= 1)
//
// Ports:
//   clk_clk          in   1  sole clock, rising edge
//   reset_reset      in   1  asynchronous, active-high reset
//   key_n            in   4  raw pushbuttons, active-low, asynchronous
//   buttons_export   out  4  debounced level, active-low, registered
//   press_pulse      out  4  one-cycle strobe per accepted press
//   release_pulse    out  4  one-cycle strobe per accepted release
//   repeat_pulse     out  4  one-cycle auto-repeat strobes while held
//
// Latency:
//   Let key_n go low and stay low. Call the first rising edge that samples
//   it low edge 1. press_pulse and buttons_export then change on edge
//   DEBOUNCE_CYCLES+3. This breaks down as:
//     - 2 edges in the synchronizer
//     - 1 edge to enter debounce
//     - DEBOUNCE_CYCLES edges of stable count
// ============================================================================

// ----------------------------------------------------------------------------
// button_sync: two-flop synchronizer for a vector of asynchronous inputs.
//   clk  in   clock
//   rst  in   asynchronous active-high reset; both flops reset to 1
//             (the idle level of an active-low key)
//   d    in   asynchronous input vector
//   q    out  synchronized vector (second flop)
// ----------------------------------------------------------------------------
module button_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: sequential state is written with non-blocking assignments so
    // every flop samples the values that existed before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// ----------------------------------------------------------------------------
// button_channel: debounce FSM and auto-repeat timer for one key.
//   clk            in   clock
//   rst            in   asynchronous active-high reset
//   s              in   synchronized key level (active-low)
//   level_n        out  debounced level, 0 while PRESSED or DB_RELEASE
//   press_pulse    out  one-cycle strobe on DB_PRESS -> PRESSED
//   release_pulse  out  one-cycle strobe on DB_RELEASE -> RELEASED
//   repeat_pulse   out  one-cycle auto-repeat strobe while held
// ----------------------------------------------------------------------------
module button_channel #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    output logic level_n,
    output logic press_pulse,
    output logic release_pulse,
    output logic repeat_pulse
);

    typedef enum logic [1:0] {
        RELEASED,
        DB_PRESS,
        PRESSED,
        DB_RELEASE
    } state_t;

    // The debounce counter only has to reach DEBOUNCE_CYCLES-1.
    // The repeat counter only has to reach the larger of its two terminal
    // values. Both counters stop at their terminal value and never wrap.
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                            : REPEAT_PERIOD;
    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  =
        RPT_W'((REPEAT_DELAY > 0) ? (REPEAT_DELAY - 1) : 0);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    state_t           state;
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    // 0 while counting toward the first repeat (REPEAT_DELAY).
    // 1 once the timer counts REPEAT_PERIOD intervals.
    logic             rpt_periodic;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= RELEASED;
            db_cnt        <= '0;
            rpt_cnt       <= '0;
            rpt_periodic  <= 1'b0;
            level_n       <= 1'b1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            // Strobes default low, so each one lasts exactly one cycle.
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            repeat_pulse  <= 1'b0;

            case (state)
                RELEASED: begin
                    rpt_cnt      <= '0;
                    rpt_periodic <= 1'b0;
                    if (!s) begin
                        state  <= DB_PRESS;
                        db_cnt <= '0;
                    end
                end

                DB_PRESS: begin
                    if (s) begin
                        state  <= RELEASED;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state        <= PRESSED;
                        level_n      <= 1'b0;
                        press_pulse  <= 1'b1;
                        rpt_cnt      <= '0;
                        rpt_periodic <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end

                PRESSED: begin
                    // Every cycle spent in PRESSED advances the repeat timer.
                    // This includes the cycle that leaves PRESSED for
                    // DB_RELEASE.
                    if (REPEAT_DELAY != 0) begin
                        if (!rpt_periodic) begin
                            if (rpt_cnt == DELAY_LAST) begin
                                repeat_pulse <= 1'b1;
                                rpt_cnt      <= '0;
                                rpt_periodic <= 1'b1;
                            end else begin
                                rpt_cnt <= rpt_cnt + RPT_W'(1);
                            end
                        end else if (rpt_cnt == PERIOD_LAST) begin
                            repeat_pulse <= 1'b1;
                            rpt_cnt      <= '0;
                        end else begin
                            rpt_cnt <= rpt_cnt + RPT_W'(1);
                        end
                    end
                    if (s) begin
                        state  <= DB_RELEASE;
                        db_cnt <= '0;
                    end
                end

                DB_RELEASE: begin
                    // The repeat timer holds its value here. A bounce that
                    // falls back to PRESSED only delays repeats by the
                    // cycles spent in this state.
                    if (!s) begin
                        state  <= PRESSED;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= RELEASED;
                        level_n       <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end

                default: begin
                    state <= RELEASED;
                end
            endcase
        end
    end

endmodule

// ----------------------------------------------------------------------------
// button_conditioner: top level, one synchronizer plus four channels.
// ----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [3:0] key_n,
    output logic [3:0] buttons_export,
    output logic [3:0] press_pulse,
    output logic [3:0] release_pulse,
    output logic [3:0] repeat_pulse
);

    logic [3:0] key_s;

    // Each channel drives only its own bit of these buses, so they are
    // declared as nets.
    wire  [3:0] level_w;
    wire  [3:0] press_w;
    wire  [3:0] release_w;
    wire  [3:0] repeat_w;

    button_sync #(
        .WIDTH (4)
    ) u_sync (
        .clk (clk_clk),
        .rst (reset_reset),
        .d   (key_n),
        .q   (key_s)
    );

    for (genvar ch = 0; ch < 4; ch++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_channel (
            .clk           (clk_clk),
            .rst           (reset_reset),
            .s             (key_s[ch]),
            .level_n       (level_w[ch]),
            .press_pulse   (press_w[ch]),
            .release_pulse (release_w[ch]),
            .repeat_pulse  (repeat_w[ch])
        );
    end

    // All four outputs come straight from channel flops; no logic is
    // added after the registers.
    assign buttons_export = level_w;
    assign press_pulse    = press_w;
    assign release_pulse  = release_w;
    assign repeat_pulse   = repeat_w;

endmodule

// File: tb/tb_button_conditioner.sv
// ============================================================================
// tb_button_conditioner
//
// Self-checking bench for button_conditioner, built with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=10 and REPEAT_PERIOD=3.
//
// The reference model works at the level of the behavioural rules:
//   - The key value the channel logic sees is the key sampled two edges
//     earlier.
//   - A level change is accepted on the (DEBOUNCE_CYCLES+1)th consecutive
//     edge at which that seen value differs from the accepted level.
//   - Repeats are timed by counting held edges, i.e. edges where the
//     accepted level is "pressed" and no release is pending. A repeat
//     fires on held count REPEAT_DELAY, then every REPEAT_PERIOD after that.
//
// The bench first runs the directed scenarios, then a randomized phase.
// Throughout, every clock edge is compared against the model.
// ============================================================================
`timescale 1ns/1ps

module tb_button_conditioner;

    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk_clk;
    logic       reset_reset;
    logic [3:0] key_n;
    logic [3:0] buttons_export;
    logic [3:0] press_pulse;
    logic [3:0] release_pulse;
    logic [3:0] repeat_pulse;

    int pass_cnt;
    int fail_cnt;
    int total_cnt;

    // Reference model state
    logic [3:0] m_k1;
    logic [3:0] m_k2;
    logic [3:0] m_seen;
    logic [3:0] m_level;
    logic [3:0] m_press;
    logic [3:0] m_rel;
    logic [3:0] m_rpt;
    int         m_run  [4];
    int         m_held [4];

    int remain [4];

    button_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset    (reset_reset),
        .key_n          (key_n),
        .buttons_export (buttons_export),
        .press_pulse    (press_pulse),
        .release_pulse  (release_pulse),
        .repeat_pulse   (repeat_pulse)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b at %0t",
                   tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_k1    = 4'hF;
        m_k2    = 4'hF;
        m_seen  = 4'hF;
        m_level = 4'hF;
        m_press = 4'h0;
        m_rel   = 4'h0;
        m_rpt   = 4'h0;
        for (int ch = 0; ch < 4; ch++) begin
            m_run[ch]  = 0;
            m_held[ch] = 0;
        end
    endtask

    // One rising edge of the reference model.
    // key_n is only changed after a tick returns, so here it still holds
    // the value the DUT sampled on this edge.
    task automatic model_step();
        if (reset_reset) begin
            model_reset();
        end else begin
            m_seen  = m_k2;
            m_k2    = m_k1;
            m_k1    = key_n;
            m_press = 4'h0;
            m_rel   = 4'h0;
            m_rpt   = 4'h0;
            for (int ch = 0; ch < 4; ch++) begin
                if (m_level[ch] == 1'b0 && m_run[ch] == 0) begin
                    m_held[ch]++;
                    if (RD != 0 && (m_held[ch] == RD ||
                        (m_held[ch] > RD && (m_held[ch] - RD) % RP == 0)))
                        m_rpt[ch] = 1'b1;
                end
                if (m_seen[ch] != m_level[ch]) m_run[ch]++;
                else                           m_run[ch] = 0;
                if (m_run[ch] == DB + 1) begin
                    m_level[ch] = m_seen[ch];
                    m_run[ch]   = 0;
                    if (m_seen[ch] == 1'b0) begin
                        m_press[ch] = 1'b1;
                        m_held[ch]  = 0;
                    end else begin
                        m_rel[ch] = 1'b1;
                    end
                end
            end
        end
    endtask

    // Advance one clock edge, step the model, then compare all outputs
    // 1 ns after the edge.
    task automatic tick();
        @(posedge clk_clk);
        model_step();
        #1;
        check("buttons_export", buttons_export, m_level);
        check("press_pulse",    press_pulse,    m_press);
        check("release_pulse",  release_pulse,  m_rel);
        check("repeat_pulse",   repeat_pulse,   m_rpt);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_buttons"}, buttons_export, 4'hF);
        check({tag, "_press"},   press_pulse,    4'h0);
        check({tag, "_release"}, release_pulse,  4'h0);
        check({tag, "_repeat"},  repeat_pulse,   4'h0);
    endtask

    initial begin
        pass_cnt    = 0;
        fail_cnt    = 0;
        total_cnt   = 0;
        key_n       = 4'hF;
        reset_reset = 1'b1;
        model_reset();

        // Reset state
        repeat (2) tick();
        check_idle("reset");
        reset_reset = 1'b0;
        repeat (3) tick();

        // Single key press, stable
        key_n = 4'b1110;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 7) check("press0_early", press_pulse, 4'b0000);
        end
        check("press0_edge7",    press_pulse,    4'b0001);
        check("press0_buttons",  buttons_export, 4'b1110);
        check("press0_release",  release_pulse,  4'b0000);
        check("press0_repeat",   repeat_pulse,   4'b0000);
        tick();
        check("press0_one_cycle", press_pulse,   4'b0000);
        check("press0_held",     buttons_export, 4'b1110);
        key_n = 4'b1111;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 7) check("release0_early", release_pulse, 4'b0000);
        end
        check("release0_edge7",   release_pulse,  4'b0001);
        check("release0_buttons", buttons_export, 4'b1111);
        repeat (5) tick();

        // Short bounce on key 1
        key_n = 4'b1101;
        repeat (3) tick();
        key_n = 4'b1111;
        for (int e = 0; e < 10; e++) begin
            tick();
            check("bounce1_buttons", buttons_export, 4'b1111);
            check("bounce1_press",   press_pulse,    4'b0000);
            check("bounce1_release", release_pulse,  4'b0000);
        end

        // Auto-repeat on key 2
        key_n = 4'b1011;
        repeat (7) tick();
        check("repeat2_press", press_pulse, 4'b0100);
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("repeat2_timing", repeat_pulse,
                  (k == 10 || k == 13 || k == 16 || k == 19) ? 4'b0100
                                                             : 4'b0000);
        end
        key_n = 4'b1111;
        for (int e = 1; e <= 7; e++) tick();
        check("repeat2_release", release_pulse, 4'b0100);
        for (int e = 0; e < 12; e++) begin
            tick();
            check("repeat2_after", repeat_pulse, 4'b0000);
        end

        // All four keys pressed in the same cycle
        key_n = 4'b0000;
        repeat (7) tick();
        check("all_press",   press_pulse,    4'b1111);
        check("all_buttons", buttons_export, 4'b0000);
        key_n = 4'b1111;
        repeat (10) tick();
        check("all_released", buttons_export, 4'b1111);

        // Reset during DB_PRESS with key 0 held low
        key_n = 4'b1110;
        repeat (4) tick();
        reset_reset = 1'b1;
        model_reset();
        #1;
        check_idle("rst_mid");
        tick();
        reset_reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 7) check("rst_repress_early", press_pulse, 4'b0000);
        end
        check("rst_repress_edge7", press_pulse, 4'b0001);

        // Two-cycle release bounce while PRESSED: repeats shift by the
        // two frozen cycles.
        repeat (4) tick();
        key_n = 4'b1111;
        repeat (2) tick();
        key_n = 4'b1110;
        for (int k = 7; k <= 16; k++) begin
            tick();
            check("freeze_repeat", repeat_pulse,
                  (k == 12 || k == 15) ? 4'b0001 : 4'b0000);
            check("freeze_release", release_pulse,  4'b0000);
            check("freeze_buttons", buttons_export, 4'b1110);
        end
        key_n = 4'b1111;
        repeat (12) tick();

        // Randomized bouncing and holding on all channels
        for (int ch = 0; ch < 4; ch++) remain[ch] = $urandom_range(1, 40);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 599) == 0) begin
                reset_reset = 1'b1;
                model_reset();
                #1;
                check_idle("rnd_rst");
                tick();
                reset_reset = 1'b0;
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (remain[ch] <= 1) begin
                    key_n[ch]  = ~key_n[ch];
                    remain[ch] = ($urandom_range(0, 1) == 1)
                                 ? int'($urandom_range(1, 6))
                                 : int'($urandom_range(5, 40));
                end else begin
                    remain[ch]--;
                end
            end
            tick();
        end

        key_n = 4'hF;
        repeat (12) tick();
        check_idle("final_idle");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
- REQ-001: Parameter DEBOUNCE_CYCLES, default 500000, SHALL set the stable-input cycles required to accept a level change (10 ms at 50 MHz), minimum 1.
- REQ-002: Parameter REPEAT_DELAY, default 25000000, SHALL set the cycles from press_pulse to first repeat_pulse; 0 disables repeat.
- REQ-003: Parameter REPEAT_PERIOD, default 5000000, SHALL set the cycles between successive repeat_pulse, minimum 1.
- REQ-004: clk_clk  input  1  sole clock; all logic on its rising edge.
- REQ-005: reset_reset  input  1  asynchronous, active-high reset.
- REQ-006: key_n  input  4  raw board pushbuttons, active-low, asynchronous, bouncing.
- REQ-007: buttons_export  output  4  debounced level, active-low, registered; feeds the system's buttons_export PIO input.
- REQ-008: press_pulse  output  4  one-cycle high per accepted press, per channel.
- REQ-009: release_pulse  output  4  one-cycle high per accepted release, per channel.
- REQ-010: repeat_pulse  output  4  one-cycle high auto-repeat strobes while held.

Function
- REQ-011: Each key_n bit SHALL pass through a 2-flop synchronizer; only the second flop's output (s) SHALL feed channel logic.
- REQ-012: The four channels SHALL be independent identical instances; simultaneous events on several channels SHALL produce pulses in the same cycle.
- REQ-013: Each channel SHALL run a 4-state FSM: RELEASED, DB_PRESS, PRESSED, DB_RELEASE.
- REQ-014: RELEASED: s=0 -> DB_PRESS with debounce counter cleared to 0; otherwise stay.
- REQ-015: DB_PRESS: s=1 -> RELEASED, counter cleared; s=0 and counter = DEBOUNCE_CYCLES-1 -> PRESSED; otherwise counter increments.
- REQ-016: PRESSED: s=1 -> DB_RELEASE, counter cleared; otherwise stay.
- REQ-017: DB_RELEASE: s=0 -> PRESSED, counter cleared; s=1 and counter = DEBOUNCE_CYCLES-1 -> RELEASED; otherwise counter increments.
- REQ-018: press_pulse SHALL be high for exactly the cycle after the DB_PRESS->PRESSED transition edge; release_pulse likewise for DB_RELEASE->RELEASED.
- REQ-019: With key_n held stable low, press_pulse SHALL rise on the (DEBOUNCE_CYCLES+3)th rising edge counting the first edge sampling key_n low as edge 1.
- REQ-020: buttons_export bit SHALL be 0 in PRESSED and DB_RELEASE, 1 in RELEASED and DB_PRESS, updating on the same edge as press_pulse/release_pulse.
- REQ-021: Repeat counter SHALL clear on entry to PRESSED from DB_PRESS, increment each cycle in PRESSED, freeze in DB_RELEASE, resume on DB_RELEASE->PRESSED, clear in RELEASED.
- REQ-022: First repeat_pulse SHALL occur REPEAT_DELAY cycles after press_pulse, then every REPEAT_PERIOD cycles while PRESSED; none if REPEAT_DELAY=0.
- REQ-023: Counter widths SHALL be ceil(log2(max parameter+1)) bits; counters SHALL never wrap past their terminal value.
- REQ-024: A bounce shorter than DEBOUNCE_CYCLES SHALL produce no pulse and no buttons_export change.

Reset
- REQ-025: reset_reset high SHALL immediately force synchronizer flops to 1, all FSMs to RELEASED, all counters to 0, buttons_export=4'b1111, all pulse outputs 0.
- REQ-026: Reset asserted mid-debounce or mid-repeat SHALL abort it without emitting any pulse.
- REQ-027: A key held low across reset deassertion SHALL be treated as a new press: full debounce, then press_pulse.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
- REQ-028: key_n[0] low, stable -> press_pulse=4'b0001 on edge 7, buttons_export=4'b1110 from edge 7; no other outputs.
- REQ-029: key_n[1] low for 3 cycles then high -> no pulses, buttons_export stays 4'b1111.
- REQ-030: key_n[2] held 20 cycles past press_pulse -> repeat_pulse[2] at +10, +13, +16, +19; release -> release_pulse[2] 7 edges after key_n rises, no further repeats.
- REQ-031: key_n[3:0] all fall same cycle -> press_pulse=4'b1111 in a single cycle.
- REQ-032: reset_reset pulsed during DB_PRESS with key_n[0] held low -> outputs return to idle at once, no pulse; press_pulse[0] 7 edges after reset deassertion.
- REQ-033: in PRESSED, key_n[0] high for 2 cycles then low -> no release_pulse, buttons_export[0] stays 0, repeat timing shifted by the frozen cycles only.
